// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the game-side control blocks.
//   ammo_state_t       : magazine state machine encoding (READY/RELOADING/EMPTY)
//   AMMO_MAG_SIZE      : default magazine capacity in rounds
//   AMMO_RESERVE_INIT  : default reserve pool after a reset or game restart
//   AMMO_RELOAD_CYCLES : default reload duration in clock cycles
// ---------------------------------------------------------------------------
package vga_pkg;

    typedef enum logic [1:0] {
        READY     = 2'd0,
        RELOADING = 2'd1,
        EMPTY     = 2'd2
    } ammo_state_t;

    localparam int AMMO_MAG_SIZE      = 6;
    localparam int AMMO_RESERVE_INIT  = 12;
    localparam int AMMO_RELOAD_CYCLES = 4;

endpackage

// File: rtl/ctl_bin2bcd.sv
// ---------------------------------------------------------------------------
// ctl_bin2bcd
// Converts an unsigned binary count into DIGITS packed BCD digits and
// registers the result, so the display path sees it one clock after the
// binary value.
//   clk   : system clock
//   rst_i : synchronous active-high clear of the BCD register
//   bin_i : binary value to convert (CTR_W bits, at most 32 bits used)
//   bcd_o : registered BCD, digit 0 in bits [3:0]
// ---------------------------------------------------------------------------
module ctl_bin2bcd #(
    parameter int CTR_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_i,
    input  logic [CTR_W-1:0]      bin_i,
    output logic [4*DIGITS-1:0]   bcd_o
);

    logic [4*DIGITS-1:0] bcd_d;
    logic [4*DIGITS-1:0] bcd_q;

    // Each digit is extracted independently as (value / 10**i) % 10; the
    // counters are small, so plain division is cheaper to reason about than
    // a shift-and-add-3 pipeline and still fits in one cycle.
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        localparam int unsigned DIV = 10 ** i;
        logic [31:0] quot;
        logic [31:0] digit;
        assign quot  = 32'(bin_i) / DIV;
        assign digit = quot % 32'd10;
        assign bcd_d[4*i +: 4] = digit[3:0];
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            bcd_q <= '0;
        end else begin
            bcd_q <= bcd_d;
        end
    end

    assign bcd_o = bcd_q;

endmodule

// File: rtl/ctl_ammo_mag.sv
// ---------------------------------------------------------------------------
// ctl_ammo_mag
// Magazine plus reserve-pool ammunition controller with timed reloads
// (manual request or automatic on empty), dry-fire reporting and a BCD
// readout of both counts for the HUD.
//   clk         : system clock
//   rst         : synchronous active-high reset
//   reset_score : synchronous active-high game restart (same effect as rst)
//   shot_fired  : trigger level, rising edge = one shot request
//   reload_req  : reload level, rising edge = one reload request
//   shot_valid  : one-cycle pulse, a round was consumed
//   dry_fire    : one-cycle pulse, a shot request was rejected
//   reloading   : high while a reload is in progress
//   no_ammo     : high while magazine and reserve are both exhausted
//   mag_ctr     : rounds in the magazine
//   reserve_ctr : rounds in the reserve pool
//   mag_bcd     : BCD of mag_ctr, one cycle behind it
//   reserve_bcd : BCD of reserve_ctr, one cycle behind it
// ---------------------------------------------------------------------------
module ctl_ammo_mag
    import vga_pkg::*;
#(
    parameter int MAG_SIZE      = AMMO_MAG_SIZE,
    parameter int RESERVE_INIT  = AMMO_RESERVE_INIT,
    parameter int RELOAD_CYCLES = AMMO_RELOAD_CYCLES,
    parameter int AUTO_RELOAD   = 1,
    parameter int CTR_W         = 8,
    parameter int DIGITS        = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reset_score,
    input  logic                  shot_fired,
    input  logic                  reload_req,
    output logic                  shot_valid,
    output logic                  dry_fire,
    output logic                  reloading,
    output logic                  no_ammo,
    output logic [CTR_W-1:0]      mag_ctr,
    output logic [CTR_W-1:0]      reserve_ctr,
    output logic [4*DIGITS-1:0]   mag_bcd,
    output logic [4*DIGITS-1:0]   reserve_bcd
);

    localparam int TMR_W = (RELOAD_CYCLES > 1) ? $clog2(RELOAD_CYCLES) : 1;
    localparam logic [CTR_W-1:0] MAG_FULL = CTR_W'(MAG_SIZE);
    localparam logic [CTR_W-1:0] RES_INIT = CTR_W'(RESERVE_INIT);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(RELOAD_CYCLES - 1);

    ammo_state_t        state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [CTR_W-1:0]   mag_q, mag_d;
    logic [CTR_W-1:0]   res_q, res_d;
    logic               shot_last_q;
    logic               reload_last_q;
    logic               shot_valid_q, shot_valid_d;
    logic               dry_fire_q, dry_fire_d;
    logic               reloading_q;
    logic               no_ammo_q;

    logic               clear;
    logic               shot_edge;
    logic               reload_edge;
    logic [CTR_W-1:0]   mag_dec;
    logic [CTR_W-1:0]   space;
    logic [CTR_W-1:0]   xfer;

    assign clear       = rst | reset_score;
    assign shot_edge   = shot_fired & ~shot_last_q;
    assign reload_edge = reload_req & ~reload_last_q;
    assign mag_dec     = mag_q - 1'b1;

    // Rounds moved by a completed reload: fill the magazine as far as the
    // reserve allows, so neither counter can wrap.
    assign space = MAG_FULL - mag_q;
    assign xfer  = (space < res_q) ? space : res_q;

    // Next-state and pulse logic. A shot request always wins over a reload
    // request in the same cycle; the reload request is simply dropped.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        mag_d        = mag_q;
        res_d        = res_q;
        shot_valid_d = 1'b0;
        dry_fire_d   = 1'b0;

        case (state_q)
            READY: begin
                if (shot_edge) begin
                    if (mag_q != '0) begin
                        mag_d        = mag_dec;
                        shot_valid_d = 1'b1;
                        if (mag_dec == '0) begin
                            if (res_q == '0) begin
                                state_d = EMPTY;
                            end else if (AUTO_RELOAD != 0) begin
                                state_d = RELOADING;
                                timer_d = TMR_LOAD;
                            end
                        end
                    end else begin
                        dry_fire_d = 1'b1;
                    end
                end else if (reload_edge && (mag_q < MAG_FULL) && (res_q != '0)) begin
                    state_d = RELOADING;
                    timer_d = TMR_LOAD;
                end
            end

            RELOADING: begin
                if (shot_edge) begin
                    dry_fire_d = 1'b1;
                end
                if (timer_q == '0) begin
                    mag_d   = mag_q + xfer;
                    res_d   = res_q - xfer;
                    state_d = READY;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end

            EMPTY: begin
                if (shot_edge) begin
                    dry_fire_d = 1'b1;
                end
            end

            default: begin
                state_d = READY;
            end
        endcase
    end

    // State and output registers. The status flags are derived from the next
    // state so they change on the same edge as the state itself; a reset in
    // the middle of a reload discards the pending transfer entirely.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q       <= READY;
            timer_q       <= '0;
            mag_q         <= MAG_FULL;
            res_q         <= RES_INIT;
            shot_last_q   <= 1'b0;
            reload_last_q <= 1'b0;
            shot_valid_q  <= 1'b0;
            dry_fire_q    <= 1'b0;
            reloading_q   <= 1'b0;
            no_ammo_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            mag_q         <= mag_d;
            res_q         <= res_d;
            shot_last_q   <= shot_fired;
            reload_last_q <= reload_req;
            shot_valid_q  <= shot_valid_d;
            dry_fire_q    <= dry_fire_d;
            reloading_q   <= (state_d == RELOADING);
            no_ammo_q     <= (state_d == EMPTY);
        end
    end

    ctl_bin2bcd #(
        .CTR_W  (CTR_W),
        .DIGITS (DIGITS)
    ) u_mag_bcd (
        .clk   (clk),
        .rst_i (clear),
        .bin_i (mag_q),
        .bcd_o (mag_bcd)
    );

    ctl_bin2bcd #(
        .CTR_W  (CTR_W),
        .DIGITS (DIGITS)
    ) u_res_bcd (
        .clk   (clk),
        .rst_i (clear),
        .bin_i (res_q),
        .bcd_o (reserve_bcd)
    );

    assign shot_valid  = shot_valid_q;
    assign dry_fire    = dry_fire_q;
    assign reloading   = reloading_q;
    assign no_ammo     = no_ammo_q;
    assign mag_ctr     = mag_q;
    assign reserve_ctr = res_q;

endmodule

// File: tb/tb_ctl_ammo_mag.sv
// ---------------------------------------------------------------------------
// tb_ctl_ammo_mag
// Directed bench for ctl_ammo_mag. Three instances share the clock and rst:
//   0 : default parameters (6 / 12 / 4 cycles, auto reload)
//   1 : RESERVE_INIT = 3
//   2 : manual reload, MAG_SIZE = 2, RESERVE_INIT = 5, RELOAD_CYCLES = 1
// Inputs change on the falling edge; outputs are sampled on the next falling
// edge, after the rising edge that reacted to them.
// ---------------------------------------------------------------------------
module tb_ctl_ammo_mag;

    logic        clk;
    logic        rst;
    logic        shot[3];
    logic        reload[3];
    logic        rscore[3];
    logic        svO[3];
    logic        dfO[3];
    logic        rlO[3];
    logic        naO[3];
    logic [7:0]  magO[3];
    logic [7:0]  resO[3];
    logic [11:0] magBcdO[3];
    logic [11:0] resBcdO[3];

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        string      tag;
        int         inst;
        logic       sv;
        logic       df;
        logic       rl;
        logic       na;
        logic [7:0] mag;
        logic [7:0] res;
        bit         chkBcd;
        logic [11:0] magBcd;
        logic [11:0] resBcd;
    } exp_t;

    exp_t expQ[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ctl_ammo_mag dut0 (
        .clk(clk), .rst(rst), .reset_score(rscore[0]),
        .shot_fired(shot[0]), .reload_req(reload[0]),
        .shot_valid(svO[0]), .dry_fire(dfO[0]), .reloading(rlO[0]), .no_ammo(naO[0]),
        .mag_ctr(magO[0]), .reserve_ctr(resO[0]),
        .mag_bcd(magBcdO[0]), .reserve_bcd(resBcdO[0])
    );

    ctl_ammo_mag #(.RESERVE_INIT(3)) dut1 (
        .clk(clk), .rst(rst), .reset_score(rscore[1]),
        .shot_fired(shot[1]), .reload_req(reload[1]),
        .shot_valid(svO[1]), .dry_fire(dfO[1]), .reloading(rlO[1]), .no_ammo(naO[1]),
        .mag_ctr(magO[1]), .reserve_ctr(resO[1]),
        .mag_bcd(magBcdO[1]), .reserve_bcd(resBcdO[1])
    );

    ctl_ammo_mag #(.MAG_SIZE(2), .RESERVE_INIT(5), .RELOAD_CYCLES(1), .AUTO_RELOAD(0)) dut2 (
        .clk(clk), .rst(rst), .reset_score(rscore[2]),
        .shot_fired(shot[2]), .reload_req(reload[2]),
        .shot_valid(svO[2]), .dry_fire(dfO[2]), .reloading(rlO[2]), .no_ammo(naO[2]),
        .mag_ctr(magO[2]), .reserve_ctr(resO[2]),
        .mag_bcd(magBcdO[2]), .reserve_bcd(resBcdO[2])
    );

    task automatic cmp(input string tag, input string fld, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s.%s: observed %0h expected %0h", tag, fld, obs, exp);
        end
    endtask

    // Drive one cycle of requests on the selected instance, others idle.
    task automatic applyStimulus(input int inst, input logic s, input logic r, input logic rs);
        for (int i = 0; i < 3; i++) begin
            shot[i]   = 1'b0;
            reload[i] = 1'b0;
            rscore[i] = 1'b0;
        end
        shot[inst]   = s;
        reload[inst] = r;
        rscore[inst] = rs;
        @(negedge clk);
    endtask

    // Pop the oldest expectation and compare it with the live outputs.
    task automatic checkOutput();
        exp_t e;
        if (expQ.size() == 0) begin
            compared++;
            mismatched++;
            $error("[TB] FAIL scoreboard: observed empty queue expected an entry");
            return;
        end
        e = expQ.pop_front();
        cmp(e.tag, "shot_valid",  32'(svO[e.inst]),  32'(e.sv));
        cmp(e.tag, "dry_fire",    32'(dfO[e.inst]),  32'(e.df));
        cmp(e.tag, "reloading",   32'(rlO[e.inst]),  32'(e.rl));
        cmp(e.tag, "no_ammo",     32'(naO[e.inst]),  32'(e.na));
        cmp(e.tag, "mag_ctr",     32'(magO[e.inst]), 32'(e.mag));
        cmp(e.tag, "reserve_ctr", 32'(resO[e.inst]), 32'(e.res));
        if (e.chkBcd) begin
            cmp(e.tag, "mag_bcd",     32'(magBcdO[e.inst]), 32'(e.magBcd));
            cmp(e.tag, "reserve_bcd", 32'(resBcdO[e.inst]), 32'(e.resBcd));
        end
    endtask

    task automatic stepFull(input string tag, input int inst,
                            input logic s, input logic r, input logic rs,
                            input logic esv, input logic edf, input logic erl, input logic ena,
                            input int emag, input int eres,
                            input bit chk, input logic [11:0] mb, input logic [11:0] rb);
        exp_t e;
        e.tag    = tag;
        e.inst   = inst;
        e.sv     = esv;
        e.df     = edf;
        e.rl     = erl;
        e.na     = ena;
        e.mag    = 8'(emag);
        e.res    = 8'(eres);
        e.chkBcd = chk;
        e.magBcd = mb;
        e.resBcd = rb;
        expQ.push_back(e);
        applyStimulus(inst, s, r, rs);
        checkOutput();
    endtask

    task automatic step(input string tag, input int inst,
                        input logic s, input logic r, input logic rs,
                        input logic esv, input logic edf, input logic erl, input logic ena,
                        input int emag, input int eres);
        stepFull(tag, inst, s, r, rs, esv, edf, erl, ena, emag, eres, 1'b0, 12'h000, 12'h000);
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            shot[i]   = 1'b0;
            reload[i] = 1'b0;
            rscore[i] = 1'b0;
        end
        repeat (3) @(negedge clk);

        // Reset values while rst is held
        stepFull("rst0", 0, 0, 0, 0, 0, 0, 0, 0, 6, 12, 1'b1, 12'h000, 12'h000);
        step("rst1", 1, 0, 0, 0, 0, 0, 0, 0, 6, 3);
        step("rst2", 2, 0, 0, 0, 0, 0, 0, 0, 2, 5);
        rst = 1'b0;
        step("idle0", 0, 0, 0, 0, 0, 0, 0, 0, 6, 12);
        stepFull("bcd0", 0, 0, 0, 0, 0, 0, 0, 0, 6, 12, 1'b1, 12'h006, 12'h012);
        stepFull("bcd1", 1, 0, 0, 0, 0, 0, 0, 0, 6, 3, 1'b1, 12'h006, 12'h003);
        stepFull("bcd2", 2, 0, 0, 0, 0, 0, 0, 0, 2, 5, 1'b1, 12'h002, 12'h005);

        // Trigger held high: only the rising edge counts
        for (int i = 0; i < 10; i++) begin
            step($sformatf("hold%0d", i), 0, 1, 0, 0, (i == 0), 0, 0, 0, 5, 12);
        end
        step("holdRel", 0, 0, 0, 0, 0, 0, 0, 0, 5, 12);

        // Empty the magazine, auto reload follows
        for (int k = 1; k <= 5; k++) begin
            step($sformatf("shotA%0d", k), 0, 1, 0, 0, 1, 0, (k == 5), 0, 5 - k, 12);
            step($sformatf("relA%0d", k), 0, 0, 0, 0, 0, 0, (k == 5), 0, 5 - k, 12);
        end
        step("dryReload", 0, 1, 0, 0, 0, 1, 1, 0, 0, 12);
        step("reloadWait", 0, 0, 0, 0, 0, 0, 1, 0, 0, 12);
        stepFull("reloadDone", 0, 0, 0, 0, 0, 0, 0, 0, 6, 6, 1'b1, 12'h000, 12'h012);
        stepFull("reloadBcd", 0, 0, 0, 0, 0, 0, 0, 0, 6, 6, 1'b1, 12'h006, 12'h006);

        // Manual reload from a partly used magazine
        for (int k = 1; k <= 2; k++) begin
            step($sformatf("shotB%0d", k), 0, 1, 0, 0, 1, 0, 0, 0, 6 - k, 6);
            step($sformatf("relB%0d", k), 0, 0, 0, 0, 0, 0, 0, 0, 6 - k, 6);
        end
        step("manReload", 0, 0, 1, 0, 0, 0, 1, 0, 4, 6);
        step("manWait1", 0, 0, 0, 0, 0, 0, 1, 0, 4, 6);
        step("manWait2", 0, 0, 0, 0, 0, 0, 1, 0, 4, 6);
        step("manWait3", 0, 0, 0, 0, 0, 0, 1, 0, 4, 6);
        step("manDone", 0, 0, 0, 0, 0, 0, 0, 0, 6, 4);
        step("fullReload", 0, 0, 1, 0, 0, 0, 0, 0, 6, 4);
        step("fullRel", 0, 0, 0, 0, 0, 0, 0, 0, 6, 4);
        step("shotWins", 0, 1, 1, 0, 1, 0, 0, 0, 5, 4);
        step("shotWinsRel", 0, 0, 0, 0, 0, 0, 0, 0, 5, 4);
        step("shotWinsIdle", 0, 0, 0, 0, 0, 0, 0, 0, 5, 4);

        // Drain everything into EMPTY
        for (int k = 1; k <= 5; k++) begin
            step($sformatf("shotC%0d", k), 0, 1, 0, 0, 1, 0, (k == 5), 0, 5 - k, 4);
            step($sformatf("relC%0d", k), 0, 0, 0, 0, 0, 0, (k == 5), 0, 5 - k, 4);
        end
        step("drainWait1", 0, 0, 0, 0, 0, 0, 1, 0, 0, 4);
        step("drainWait2", 0, 0, 0, 0, 0, 0, 1, 0, 0, 4);
        step("drainReload", 0, 0, 0, 0, 0, 0, 0, 0, 4, 0);
        for (int k = 1; k <= 4; k++) begin
            step($sformatf("shotD%0d", k), 0, 1, 0, 0, 1, 0, 0, (k == 4), 4 - k, 0);
            step($sformatf("relD%0d", k), 0, 0, 0, 0, 0, 0, 0, (k == 4), 4 - k, 0);
        end
        step("emptyDry", 0, 1, 0, 0, 0, 1, 0, 1, 0, 0);
        step("emptyRel", 0, 0, 1, 0, 0, 0, 0, 1, 0, 0);
        stepFull("rscore", 0, 0, 0, 1, 0, 0, 0, 0, 6, 12, 1'b1, 12'h000, 12'h000);
        step("rscoreIdle", 0, 0, 0, 0, 0, 0, 0, 0, 6, 12);
        stepFull("rscoreBcd", 0, 0, 0, 0, 0, 0, 0, 0, 6, 12, 1'b1, 12'h006, 12'h012);

        // Small reserve: partial reload then EMPTY without a reload
        for (int k = 1; k <= 6; k++) begin
            step($sformatf("shotE%0d", k), 1, 1, 0, 0, 1, 0, (k == 6), 0, 6 - k, 3);
            step($sformatf("relE%0d", k), 1, 0, 0, 0, 0, 0, (k == 6), 0, 6 - k, 3);
        end
        step("partWait1", 1, 0, 0, 0, 0, 0, 1, 0, 0, 3);
        step("partWait2", 1, 0, 0, 0, 0, 0, 1, 0, 0, 3);
        step("partDone", 1, 0, 0, 0, 0, 0, 0, 0, 3, 0);
        for (int k = 1; k <= 3; k++) begin
            step($sformatf("shotF%0d", k), 1, 1, 0, 0, 1, 0, 0, (k == 3), 3 - k, 0);
            step($sformatf("relF%0d", k), 1, 0, 0, 0, 0, 0, 0, (k == 3), 3 - k, 0);
        end
        step("partDry", 1, 1, 0, 0, 0, 1, 0, 1, 0, 0);
        stepFull("partBcd", 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1'b1, 12'h000, 12'h000);

        // Manual mode: empty magazine stays READY and dry-fires
        for (int k = 1; k <= 2; k++) begin
            step($sformatf("shotG%0d", k), 2, 1, 0, 0, 1, 0, 0, 0, 2 - k, 5);
            step($sformatf("relG%0d", k), 2, 0, 0, 0, 0, 0, 0, 0, 2 - k, 5);
        end
        step("manDry", 2, 1, 0, 0, 0, 1, 0, 0, 0, 5);
        step("manDryRel", 2, 0, 0, 0, 0, 0, 0, 0, 0, 5);
        step("manRl", 2, 0, 1, 0, 0, 0, 1, 0, 0, 5);
        step("manRlDone", 2, 0, 0, 0, 0, 0, 0, 0, 2, 3);

        // rst in the middle of a reload: no partial transfer
        step("midShot", 0, 1, 0, 0, 1, 0, 0, 0, 5, 12);
        step("midRel", 0, 0, 0, 0, 0, 0, 0, 0, 5, 12);
        step("midReload", 0, 0, 1, 0, 0, 0, 1, 0, 5, 12);
        step("midWait", 0, 0, 0, 0, 0, 0, 1, 0, 5, 12);
        rst = 1'b1;
        step("midRst", 0, 0, 0, 0, 0, 0, 0, 0, 6, 12);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step($sformatf("postRst%0d", k), 0, 0, 0, 0, 0, 0, 0, 0, 6, 12);
        end
        step("postRst1", 1, 0, 0, 0, 0, 0, 0, 0, 6, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
